// File: rtl/quadrature_generator.sv
// Quadrature encoder emulator: turns step commands into a Gray-coded A/B
// pair and tracks a signed position alongside the emitted edges.
module quadrature_generator #(
  parameter int STEP_W = 16,
  parameter int DIV_W  = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_dir,
  input  logic [STEP_W-1:0] cmd_steps,
  input  logic [DIV_W-1:0]  cmd_period,
  input  logic              abort,
  output logic              a,
  output logic              b,
  output logic              busy,
  output logic              done,
  output logic [31:0]       position
);

  typedef enum logic {
    IDLE,
    RUN
  } state_t;

  state_t state, state_nxt;

  logic              dir_q;
  logic [STEP_W-1:0] remaining;
  logic [DIV_W-1:0]  period_q;
  logic [DIV_W-1:0]  timer;
  logic [DIV_W-1:0]  period_eff;
  logic              accept;
  logic              step_en;
  logic              last_step;

  assign cmd_ready = (state == IDLE);
  assign busy      = (state == RUN);

  always_comb begin
    period_eff = cmd_period;
    if (cmd_period == '0)
      period_eff = DIV_W'(1);
  end

  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    step_en   = 1'b0;
    last_step = 1'b0;
    unique case (state)
      IDLE: begin
        if (cmd_valid) begin
          accept = 1'b1;
          if (cmd_steps != '0)
            state_nxt = RUN;
        end
      end
      RUN: begin
        // abort beats a coincident step
        if (abort) begin
          state_nxt = IDLE;
        end else if (timer == DIV_W'(1)) begin
          step_en = 1'b1;
          if (remaining == STEP_W'(1)) begin
            last_step = 1'b1;
            state_nxt = IDLE;
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      state <= IDLE;
    else
      state <= state_nxt;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      dir_q     <= 1'b0;
      remaining <= '0;
      period_q  <= '0;
      timer     <= '0;
      a         <= 1'b0;
      b         <= 1'b0;
      position  <= '0;
      done      <= 1'b0;
    end else begin
      done <= 1'b0;
      if (accept) begin
        dir_q     <= cmd_dir;
        remaining <= cmd_steps;
        period_q  <= period_eff;
        timer     <= period_eff;
        done      <= (cmd_steps == '0);
      end else if (busy && !abort) begin
        if (step_en) begin
          timer     <= period_q;
          remaining <= remaining - STEP_W'(1);
          done      <= last_step;
          // forward walks 00,10,11,01; reverse walks it backwards
          if (dir_q) begin
            a        <= ~b;
            b        <= a;
            position <= position + 32'd1;
          end else begin
            a        <= b;
            b        <= ~a;
            position <= position - 32'd1;
          end
        end else begin
          timer <= timer - DIV_W'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_quadrature_generator.sv
// Scoreboard bench for quadrature_generator: stimulus queues expected
// edges and done pulses, a monitor pops them as the DUT produces them.
module tb_quadrature_generator;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic        cmd_dir = 1'b0;
  logic [15:0] cmd_steps = '0;
  logic [15:0] cmd_period = '0;
  logic        abort = 1'b0;
  logic        a, b, busy, done;
  logic [31:0] position;

  quadrature_generator #(
    .STEP_W(16),
    .DIV_W (16)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_dir   (cmd_dir),
    .cmd_steps (cmd_steps),
    .cmd_period(cmd_period),
    .abort     (abort),
    .a         (a),
    .b         (b),
    .busy      (busy),
    .done      (done),
    .position  (position)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int fails  = 0;

  typedef struct {
    bit          is_done;
    int          cyc;
    logic [1:0]  ab;
    logic [31:0] pos;
  } ev_t;

  ev_t sb[$];

  logic [1:0]  mab = 2'b00;
  logic [31:0] mpos = '0;
  logic        last_dir = 1'b0;
  bit          had_step = 1'b0;

  function automatic logic [1:0] fwd(input logic [1:0] s);
    case (s)
      2'b00:   return 2'b10;
      2'b10:   return 2'b11;
      2'b11:   return 2'b01;
      default: return 2'b00;
    endcase
  endfunction

  function automatic logic [1:0] rev(input logic [1:0] s);
    case (s)
      2'b00:   return 2'b01;
      2'b01:   return 2'b11;
      2'b11:   return 2'b10;
      default: return 2'b00;
    endcase
  endfunction

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h (cyc %0d)", name, act, exp, cyc);
    end
  endtask

  // reference decoder: 2-flop history, counts on each valid Gray transition
  logic [1:0]  s1, s2;
  logic [31:0] dec_count;
  logic        dec_dir;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      s1 <= 2'b00;
      s2 <= 2'b00;
      dec_count <= '0;
      dec_dir <= 1'b0;
    end else begin
      s1 <= {a, b};
      s2 <= s1;
      if (s1 != s2) begin
        if (fwd(s2) == s1) begin
          dec_count <= dec_count + 32'd1;
          dec_dir <= 1'b1;
        end else if (rev(s2) == s1) begin
          dec_count <= dec_count - 32'd1;
          dec_dir <= 1'b0;
        end
      end
    end
  end

  // monitor
  initial begin
    logic [1:0]  prev_ab;
    logic [31:0] prev_pos;
    ev_t         e;
    prev_ab  = 2'b00;
    prev_pos = '0;
    forever begin
      @(negedge clk);
      if (reset) begin
        prev_ab  = {a, b};
        prev_pos = position;
        continue;
      end
      if ({a, b} != prev_ab) begin
        if (sb.size() == 0) begin
          checks++;
          fails++;
          $display("FAIL unexpected_step: got ab=%b expected no edge (cyc %0d)",
                   {a, b}, cyc);
        end else begin
          e = sb.pop_front();
          chk("step_kind", 32'(e.is_done), 32'd0);
          chk("step_cycle", cyc, e.cyc);
          chk("step_ab", 32'({a, b}), 32'(e.ab));
          chk("step_pos", position, e.pos);
        end
      end else if (position != prev_pos) begin
        checks++;
        fails++;
        $display("FAIL pos_without_edge: got %h expected %h", position, prev_pos);
      end
      prev_ab  = {a, b};
      prev_pos = position;
      if (done) begin
        if (sb.size() == 0) begin
          checks++;
          fails++;
          $display("FAIL unexpected_done: got done=1 expected 0 (cyc %0d)", cyc);
        end else begin
          e = sb.pop_front();
          chk("done_kind", 32'(e.is_done), 32'd1);
          chk("done_cycle", cyc, e.cyc);
          chk("done_pos", position, e.pos);
        end
      end
    end
  end

  task automatic send(input logic d, input int n, input int p,
                      input int emit, input bit exp_done, output int k);
    int  pe;
    int  w;
    ev_t e;
    cmd_dir    = d;
    cmd_steps  = 16'(n);
    cmd_period = 16'(p);
    cmd_valid  = 1'b1;
    w = 0;
    while (!cmd_ready && w < 2000) begin
      @(negedge clk);
      w++;
    end
    chk("accept_ready", 32'(cmd_ready), 32'd1);
    @(posedge clk);
    #1;
    k = cyc;
    cmd_valid = 1'b0;
    pe = (p == 0) ? 1 : p;
    for (int i = 1; i <= emit; i++) begin
      mab  = d ? fwd(mab) : rev(mab);
      mpos = d ? mpos + 32'd1 : mpos - 32'd1;
      last_dir = d;
      had_step = 1'b1;
      e.is_done = 1'b0;
      e.cyc = k + i * pe;
      e.ab = mab;
      e.pos = mpos;
      sb.push_back(e);
    end
    if (exp_done) begin
      e.is_done = 1'b1;
      e.cyc = k + n * pe;
      e.ab = mab;
      e.pos = mpos;
      sb.push_back(e);
    end
  endtask

  task automatic wait_until(input int c);
    while (cyc < c) @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    #1 reset = 1'b1;
    mab = 2'b00;
    mpos = '0;
    had_step = 1'b0;
    @(negedge clk);
    #2 reset = 1'b0;
  endtask

  initial begin
    #200000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int k, k2;
    #12;
    chk("rst_ab", 32'({a, b}), 32'd0);
    chk("rst_pos", position, 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_ready", 32'(cmd_ready), 32'd1);
    @(negedge clk);
    #2 reset = 1'b0;

    // forward 4 steps, period 3
    send(1'b1, 4, 3, 4, 1'b1, k);
    chk("fwd_busy", 32'(busy), 32'd1);
    chk("fwd_ready_low", 32'(cmd_ready), 32'd0);
    wait_until(k + 12);
    chk("fwd_pos", position, 32'd4);
    chk("fwd_ab", 32'({a, b}), 32'b00);
    chk("fwd_done", 32'(done), 32'd1);
    chk("fwd_ready", 32'(cmd_ready), 32'd1);
    @(negedge clk);
    chk("fwd_done_1cyc", 32'(done), 32'd0);

    // reverse through zero
    do_reset();
    send(1'b0, 3, 1, 3, 1'b1, k);
    wait_until(k + 3);
    chk("rev_pos", position, 32'hFFFF_FFFD);
    chk("rev_ab", 32'({a, b}), 32'b10);

    // zero steps
    send(1'b1, 0, 5, 0, 1'b1, k);
    chk("zero_busy", 32'(busy), 32'd0);
    wait_until(k + 2);
    chk("zero_ab", 32'({a, b}), 32'b10);
    chk("zero_busy2", 32'(busy), 32'd0);

    // period 0 behaves as 1
    send(1'b1, 2, 0, 2, 1'b1, k);
    wait_until(k + 2);
    chk("p0_ab", 32'({a, b}), 32'b01);
    chk("p0_pos", position, 32'hFFFF_FFFF);

    // abort on the 3rd step edge with a second command held off
    do_reset();
    send(1'b1, 10, 4, 2, 1'b0, k);
    cmd_dir = 1'b0;
    cmd_steps = 16'd3;
    cmd_period = 16'd2;
    cmd_valid = 1'b1;
    while (cyc < k + 11) @(negedge clk);
    abort = 1'b1;
    @(posedge clk);
    #1 abort = 1'b0;
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_pos", position, 32'd2);
    chk("abort_ab", 32'({a, b}), 32'b11);
    send(1'b0, 3, 2, 3, 1'b1, k2);
    chk("held_accept_cycle", k2, k + 13);
    wait_until(k2 + 7);
    chk("held_pos", position, 32'hFFFF_FFFF);

    // async reset mid-run
    send(1'b1, 8, 2, 2, 1'b0, k);
    wait_until(k + 4);
    #1 reset = 1'b1;
    mab = 2'b00;
    mpos = '0;
    had_step = 1'b0;
    #1;
    chk("mid_rst_ab", 32'({a, b}), 32'd0);
    chk("mid_rst_pos", position, 32'd0);
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk("mid_rst_ready", 32'(cmd_ready), 32'd1);
    @(negedge clk);
    #2 reset = 1'b0;
    repeat (20) @(negedge clk);
    chk("mid_rst_idle", 32'(busy), 32'd0);

    // decoder loopback
    for (int i = 0; i < 200; i++) begin
      logic d;
      int   n, p;
      d = 1'($urandom_range(0, 1));
      n = $urandom_range(0, 50);
      p = $urandom_range(1, 5);
      send(d, n, p, n, 1'b1, k);
      wait_until(k + n * p + 3);
      chk("loop_count", dec_count, mpos);
      if (had_step)
        chk("loop_dir", 32'(dec_dir), 32'(last_dir));
    end

    repeat (5) @(negedge clk);
    chk("sb_drained", sb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures",
             checks, fails);
    $finish;
  end

endmodule
